control_sequencer: RTL and testbench

//   Hardwired control unit driving the DataPath control inputs (PCout, MARin, IncPC, Zlowin, ...)

---
 rtl/control_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit driving the DataPath strobes
// Moore outputs decoded from the state register and the IR opcode/register fields.
module control_sequencer #(
    parameter int OPW     = 5,
    parameter int RW      = 4,
    parameter int RD_WAIT = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic [31:0]           ir,
    input  logic                  mem_ready,
    output logic                  PCout,
    output logic                  Zlowout,
    output logic                  MDRout,
    output logic                  MARin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  IncPC,
    output logic                  Read,
    output logic                  Zlowin,
    output logic [(1<<RW)-1:0]    Rin_sel,
    output logic [(1<<RW)-1:0]    Rout_sel,
    output logic [OPW-1:0]        alu_op,
    output logic                  halted,
    output logic [2:0]            step
);

    localparam int NREG = 1 << RW;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALTED
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OPW-1:0]  op;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [RW-1:0]   rc;
    logic [NREG-1:0] ra_oh;
    logic [NREG-1:0] rb_oh;
    logic [NREG-1:0] rc_oh;
    logic            is_alu;
    logic            is_unary;
    logic            is_halt;
    logic            t1_exit;
    state_t          end_next;
    logic            unused_ir_bits;

    assign op = ir[31 -: OPW];
    assign ra = ir[31-OPW -: RW];
    assign rb = ir[31-OPW-RW -: RW];
    assign rc = ir[31-OPW-2*RW -: RW];
    assign unused_ir_bits = ^ir[31-OPW-3*RW:0];

    assign ra_oh = {{(NREG-1){1'b0}}, 1'b1} << ra;
    assign rb_oh = {{(NREG-1){1'b0}}, 1'b1} << rb;
    assign rc_oh = {{(NREG-1){1'b0}}, 1'b1} << rc;

    assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_unary = (op == OP_NEG) || (op == OP_NOT);
    assign is_halt  = (op == OP_HALT);

    // Without the wait option the read is assumed to complete in one cycle.
    assign t1_exit  = (RD_WAIT == 0) || mem_ready;
    assign end_next = run ? S_T0 : S_IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     if (t1_exit) state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3: begin
                if (is_halt)                  state_d = S_HALTED;
                else if (is_alu || is_unary)  state_d = S_T4;
                else                          state_d = end_next;
            end
            S_T4:     state_d = is_alu ? S_T5 : end_next;
            S_T5:     state_d = end_next;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Zlowin   = 1'b0;
        Rin_sel  = '0;
        Rout_sel = '0;
        alu_op   = '0;
        halted   = 1'b0;
        step     = 3'd7;
        case (state_q)
            S_T0: begin
                step  = 3'd0;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                step  = 3'd1;
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC load only on the exit cycle so a stalled read increments PC once.
                Zlowout = t1_exit;
                PCin    = t1_exit;
            end
            S_T2: begin
                step   = 3'd2;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                step = 3'd3;
                if (is_alu) begin
                    Rout_sel = rb_oh;
                    Yin      = 1'b1;
                end else if (is_unary) begin
                    Rout_sel = rb_oh;
                    alu_op   = op;
                    Zlowin   = 1'b1;
                end
            end
            S_T4: begin
                step = 3'd4;
                if (is_alu) begin
                    Rout_sel = rc_oh;
                    alu_op   = op;
                    Zlowin   = 1'b1;
                end else if (is_unary) begin
                    Zlowout = 1'b1;
                    Rin_sel = ra_oh;
                end
            end
            S_T5: begin
                step    = 3'd5;
                Zlowout = 1'b1;
                Rin_sel = ra_oh;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                step = 3'd7;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

    localparam logic [10:0] B_PCOUT   = 11'h400;
    localparam logic [10:0] B_ZLOWOUT = 11'h200;
    localparam logic [10:0] B_MDROUT  = 11'h100;
    localparam logic [10:0] B_MARIN   = 11'h080;
    localparam logic [10:0] B_PCIN    = 11'h040;
    localparam logic [10:0] B_MDRIN   = 11'h020;
    localparam logic [10:0] B_IRIN    = 11'h010;
    localparam logic [10:0] B_YIN     = 11'h008;
    localparam logic [10:0] B_INCPC   = 11'h004;
    localparam logic [10:0] B_READ    = 11'h002;
    localparam logic [10:0] B_ZLOWIN  = 11'h001;

    logic        clock = 1'b0;
    logic [1:0]  clr;
    logic [1:0]  run_v;
    logic [1:0]  mr;
    logic [31:0] ir0;
    logic [31:0] ir1;

    wire [10:0] s0, s1;
    wire [15:0] rin0, rout0, rin1, rout1;
    wire [4:0]  alu0, alu1;
    wire        h0, h1;
    wire [2:0]  st0, st1;
    wire [51:0] obs0 = {s0, rin0, rout0, alu0, h0, st0};
    wire [51:0] obs1 = {s1, rin1, rout1, alu1, h1, st1};

    int errors = 0;
    int checks = 0;
    int instr_no = 0;
    bit idle_q [2];
    logic [15:0] acc_rin, acc_rout;
    logic [4:0]  acc_alu;
    int          acc_cyc;

    always #5 clock = ~clock;

    control_sequencer #(.OPW(5), .RW(4), .RD_WAIT(0)) u_nowait (
        .clock(clock), .clear(clr[0]), .run(run_v[0]), .ir(ir0), .mem_ready(mr[0]),
        .PCout(s0[10]), .Zlowout(s0[9]), .MDRout(s0[8]), .MARin(s0[7]), .PCin(s0[6]),
        .MDRin(s0[5]), .IRin(s0[4]), .Yin(s0[3]), .IncPC(s0[2]), .Read(s0[1]), .Zlowin(s0[0]),
        .Rin_sel(rin0), .Rout_sel(rout0), .alu_op(alu0), .halted(h0), .step(st0)
    );

    control_sequencer #(.OPW(5), .RW(4), .RD_WAIT(1)) u_wait (
        .clock(clock), .clear(clr[1]), .run(run_v[1]), .ir(ir1), .mem_ready(mr[1]),
        .PCout(s1[10]), .Zlowout(s1[9]), .MDRout(s1[8]), .MARin(s1[7]), .PCin(s1[6]),
        .MDRin(s1[5]), .IRin(s1[4]), .Yin(s1[3]), .IncPC(s1[2]), .Read(s1[1]), .Zlowin(s1[0]),
        .Rin_sel(rin1), .Rout_sel(rout1), .alu_op(alu1), .halted(h1), .step(st1)
    );

    function automatic logic [51:0] mk(input logic [10:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [4:0] alu,
                                       input logic h, input logic [2:0] st);
        return {s, rin, rout, alu, h, st};
    endfunction

    // 1 = reg-reg ALU, 2 = unary, 3 = halt, 0 = no-op (including undefined opcodes)
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: return 1;
            5'd17, 5'd18:           return 2;
            5'd27:                  return 3;
            default:                return 0;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (instr %0d): got=%0h expected=%0h", nm, instr_no, got, exp);
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks the outputs.
    task automatic cyc(input int sel, input logic r, input logic [31:0] irv, input logic m,
                       input logic [51:0] exp, input string nm);
        logic [51:0] got;
        if (sel == 0) begin
            run_v[0] = r; ir0 = irv; mr[0] = m;
        end else begin
            run_v[1] = r; ir1 = irv; mr[1] = m;
        end
        @(negedge clock);
        got = (sel == 0) ? obs0 : obs1;
        check(nm, 64'(got), 64'(exp));
        if (got[2:0] != 3'd7) begin
            acc_cyc++;
            acc_rin  = acc_rin | got[40:25];
            acc_rout = acc_rout | got[24:9];
            acc_alu  = acc_alu | got[8:4];
        end
        @(posedge clock);
        #1;
    endtask

    // Expands one instruction into its expected cycle schedule and plays it.
    task automatic run_instr(input int sel, input logic [31:0] irv, input int w,
                             input logic lr, input int hold_halt);
        logic [4:0]  op;
        logic [15:0] oha, ohb, ohc;
        int          eff;
        int          cls;
        op  = irv[31:27];
        oha = 16'd1 << irv[26:23];
        ohb = 16'd1 << irv[22:19];
        ohc = 16'd1 << irv[18:15];
        cls = op_class(op);
        eff = (sel == 1) ? w : 0;
        instr_no++;
        acc_rin = '0; acc_rout = '0; acc_alu = '0; acc_cyc = 0;
        if (idle_q[sel]) cyc(sel, 1'b1, $urandom, rbit(), mk(0, 0, 0, 0, 0, 3'd7), "idle_start");
        cyc(sel, rbit(), $urandom, rbit(), mk(B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN, 0, 0, 0, 0, 3'd0), "t0");
        for (int i = 0; i < eff; i++)
            cyc(sel, rbit(), $urandom, 1'b0, mk(B_READ | B_MDRIN, 0, 0, 0, 0, 3'd1), "t1_wait");
        cyc(sel, rbit(), $urandom, (sel == 0 && w > 0) ? 1'b0 : 1'b1,
            mk(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 0, 0, 0, 0, 3'd1), "t1_exit");
        cyc(sel, rbit(), $urandom, rbit(), mk(B_MDROUT | B_IRIN, 0, 0, 0, 0, 3'd2), "t2");
        if (cls == 1) begin
            cyc(sel, rbit(), irv, rbit(), mk(B_YIN, 0, ohb, 0, 0, 3'd3), "t3_alu");
            cyc(sel, rbit(), irv, rbit(), mk(B_ZLOWIN, 0, ohc, op, 0, 3'd4), "t4_alu");
            cyc(sel, lr, irv, rbit(), mk(B_ZLOWOUT, oha, 0, 0, 0, 3'd5), "t5_alu");
        end else if (cls == 2) begin
            cyc(sel, rbit(), irv, rbit(), mk(B_ZLOWIN, 0, ohb, op, 0, 3'd3), "t3_unary");
            cyc(sel, lr, irv, rbit(), mk(B_ZLOWOUT, oha, 0, 0, 0, 3'd4), "t4_unary");
        end else if (cls == 3) begin
            cyc(sel, rbit(), irv, rbit(), mk(0, 0, 0, 0, 0, 3'd3), "t3_halt");
            for (int i = 0; i < hold_halt; i++)
                cyc(sel, 1'b1, irv, rbit(), mk(0, 0, 0, 0, 1'b1, 3'd7), "halted");
        end else begin
            cyc(sel, lr, irv, rbit(), mk(0, 0, 0, 0, 0, 3'd3), "t3_nop");
        end
        idle_q[sel] = !lr;
    endtask

    typedef struct {
        logic [31:0] ir;
        int          sel;
        int          w;
        logic        lr;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        int          ncyc;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] irv;
        logic [4:0]  op;
        int          k;
        int          sel;
        logic        lr;
        bit          pending;

        tbl[0] = '{32'h18918000, 0, 0, 1'b1, 16'h0002, 16'h000C, 5'd3,  6};
        tbl[1] = '{32'h88900000, 0, 0, 1'b0, 16'h0002, 16'h0004, 5'd17, 5};
        tbl[2] = '{32'h18918000, 1, 3, 1'b1, 16'h0002, 16'h000C, 5'd3,  9};
        tbl[3] = '{32'hD0000000, 1, 0, 1'b1, 16'h0000, 16'h0000, 5'd0,  4};
        tbl[4] = '{32'hFFFFFFFF, 1, 1, 1'b0, 16'h0000, 16'h0000, 5'd0,  5};
        tbl[5] = '{32'h307B8000, 0, 0, 1'b0, 16'h0001, 16'h8080, 5'd6,  6};
        tbl[6] = '{32'h97800000, 1, 1, 1'b1, 16'h8000, 16'h0001, 5'd18, 6};
        tbl[7] = '{32'h2F6E0000, 1, 0, 1'b0, 16'h4000, 16'h3000, 5'd5,  6};
        tbl[8] = '{32'h21A28000, 0, 2, 1'b0, 16'h0008, 16'h0030, 5'd4,  6};

        clr = 2'b00; run_v = 2'b00; mr = 2'b00; ir0 = '0; ir1 = '0;
        idle_q[0] = 1'b1; idle_q[1] = 1'b1;
        @(posedge clock);
        #1;
        check("reset_nowait", 64'(obs0), 64'(mk(0, 0, 0, 0, 0, 3'd7)));
        check("reset_wait", 64'(obs1), 64'(mk(0, 0, 0, 0, 0, 3'd7)));
        @(posedge clock);
        #1;
        clr = 2'b11;

        for (int i = 0; i < 9; i++) begin
            run_instr(tbl[i].sel, tbl[i].ir, tbl[i].w, tbl[i].lr, 0);
            check($sformatf("tbl%0d_rin", i), 64'(acc_rin), 64'(tbl[i].rin));
            check($sformatf("tbl%0d_rout", i), 64'(acc_rout), 64'(tbl[i].rout));
            check($sformatf("tbl%0d_alu", i), 64'(acc_alu), 64'(tbl[i].alu));
            check($sformatf("tbl%0d_cycles", i), 64'(acc_cyc), 64'(tbl[i].ncyc));
        end

        pending = 1'b0;
        sel = 0;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4)       op = 5'(3 + k);
            else if (k < 6)  op = 5'(17 + k - 4);
            else if (k == 6) op = 5'd26;
            else             op = 5'($urandom);
            if (op == 5'd27) op = 5'd26;
            irv = {op, 27'($urandom)};
            if (!pending) sel = $urandom_range(0, 1);
            lr = (n == 39) ? 1'b0 : rbit();
            run_instr(sel, irv, $urandom_range(0, 3), lr, 0);
            pending = lr;
        end

        // clear dropped in the middle of T4 of an ADD on the no-wait unit
        instr_no++;
        cyc(0, 1'b1, $urandom, 1'b1, mk(0, 0, 0, 0, 0, 3'd7), "c_idle");
        cyc(0, 1'b1, $urandom, 1'b1, mk(B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN, 0, 0, 0, 0, 3'd0), "c_t0");
        cyc(0, 1'b1, $urandom, 1'b1, mk(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 0, 0, 0, 0, 3'd1), "c_t1");
        cyc(0, 1'b1, $urandom, 1'b1, mk(B_MDROUT | B_IRIN, 0, 0, 0, 0, 3'd2), "c_t2");
        cyc(0, 1'b1, 32'h18918000, 1'b1, mk(B_YIN, 0, 16'h0004, 0, 0, 3'd3), "c_t3");
        run_v[0] = 1'b1;
        @(negedge clock);
        check("c_t4", 64'(obs0), 64'(mk(B_ZLOWIN, 0, 16'h0008, 5'd3, 0, 3'd4)));
        clr[0] = 1'b0;
        #1;
        check("c_clear_now", 64'(obs0), 64'(mk(0, 0, 0, 0, 0, 3'd7)));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("c_clear_hold", 64'(obs0), 64'(mk(0, 0, 0, 0, 0, 3'd7)));
        @(posedge clock);
        #1;
        clr[0] = 1'b1;
        idle_q[0] = 1'b1;
        run_instr(0, 32'h18918000, 0, 1'b0, 0);
        check("c_restart_rin", 64'(acc_rin), 64'h0002);

        // HALT is sticky with run held high; only clear leaves it
        run_instr(1, 32'hD8000000, 2, 1'b1, 20);
        @(negedge clock);
        clr[1] = 1'b0;
        #1;
        check("halt_clear", 64'(obs1), 64'(mk(0, 0, 0, 0, 0, 3'd7)));
        @(posedge clock);
        #1;
        clr[1] = 1'b1;
        idle_q[1] = 1'b1;
        run_instr(1, 32'h88900000, 1, 1'b0, 0);
        check("halt_recover_alu", 64'(acc_alu), 64'h11);
        check("halt_recover_cycles", 64'(acc_cyc), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
